// File: rtl/dsp_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : dsp_fetch_unit
// Description : Instruction fetch / program-counter unit for the DSP core.
//               It owns the PC and reads instruction words from instruction
//               memory over a req/ack handshake. It issues one instruction at
//               a time to the decoder, which can hold it off with stall.
//               Taken jumps from the branch unit redirect the PC. A jump
//               squashes any instruction that is in flight or being held.
//               halt parks the unit until the next reset.
// Ports       :
//   clk          in   1        core clock, rising edge
//   rst          in   1        synchronous active-high reset
//   jump_flag    in   1        taken jump this cycle (branch unit)
//   jump_addr    in   ADDR_W   jump target, valid with jump_flag
//   stall        in   1        decoder cannot accept instr this cycle
//   halt         in   1        stop fetching, sticky until rst
//   imem_req     out  1        memory read request
//   imem_addr    out  ADDR_W   memory read address, stable while imem_req=1
//   imem_ack     in   1        read data valid
//   imem_data    in   INSTR_W  read data, sampled when imem_ack=1
//   instr        out  INSTR_W  instruction to decoder
//   instr_pc     out  ADDR_W   address of instr
//   instr_valid  out  1        instr/instr_pc valid, held until consumed
//   pc_wrap      out  1        one-cycle pulse after PC wraps all-ones -> 0
//   halted       out  1        unit is parked in HALTED
// Revision    : 1.0  initial release
// ============================================================================
module dsp_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               stall,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               pc_wrap,
    output logic               halted
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_START  = 2'd0;
    localparam logic [1:0] c_ST_FETCH  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE  = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    localparam logic [ADDR_W-1:0] c_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PC_ONES = {ADDR_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [ADDR_W-1:0]  pc_q,        pc_d;
    // squash_q: the outstanding request has been overtaken by a jump; its
    // ack is to be thrown away. hold_addr_q keeps the address of that
    // request on imem_addr because the address may not move before ack.
    logic               squash_q,    squash_d;
    logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
    // gap_q: an ack was just discarded; keep req low for one cycle so the
    // memory sees a clean new request at the redirected PC.
    logic               gap_q,       gap_d;
    logic [INSTR_W-1:0] instr_q,     instr_d;
    logic [ADDR_W-1:0]  instr_pc_q,  instr_pc_d;
    logic               valid_q,     valid_d;
    logic               wrap_q,      wrap_d;

    logic               w_req;
    logic               w_ack;

    // ------------------------------------------------------------------
    // Memory-side outputs
    // ------------------------------------------------------------------
    assign w_req     = (state_q == c_ST_FETCH) && !gap_q;
    // An ack only counts while a request is actually up; stray acks in
    // START, ISSUE, HALTED or the gap cycle are ignored.
    assign w_ack     = w_req && imem_ack;

    assign imem_req  = w_req;
    assign imem_addr = squash_q ? hold_addr_q : pc_q;

    // ------------------------------------------------------------------
    // Decoder-side outputs
    // ------------------------------------------------------------------
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign pc_wrap     = wrap_q;
    assign halted      = (state_q == c_ST_HALTED);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        hold_addr_d = hold_addr_q;
        gap_d       = 1'b0;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        wrap_d      = 1'b0;

        case (state_q)
            c_ST_START: begin
                if (jump_flag) begin
                    pc_d = jump_addr;
                end
                state_d = c_ST_FETCH;
            end

            c_ST_FETCH: begin
                if (w_ack) begin
                    if (squash_q || jump_flag) begin
                        // Returned word belongs to a path that has been
                        // redirected: drop it and refetch after the gap.
                        squash_d = 1'b0;
                        gap_d    = 1'b1;
                        if (jump_flag) begin
                            pc_d = jump_addr;
                        end
                    end else begin
                        instr_d    = imem_data;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = c_ST_ISSUE;
                    end
                end else if (jump_flag) begin
                    pc_d = jump_addr;
                    // Only the first jump over a live request captures its
                    // address; later jumps just retarget the PC.
                    if (w_req && !squash_q) begin
                        squash_d    = 1'b1;
                        hold_addr_d = pc_q;
                    end
                end
            end

            c_ST_ISSUE: begin
                if (jump_flag) begin
                    // Held instruction is on the wrong path, stall or not.
                    valid_d = 1'b0;
                    pc_d    = jump_addr;
                    state_d = c_ST_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + c_PC_ONE;
                    wrap_d  = (pc_q == c_PC_ONES);
                    state_d = c_ST_FETCH;
                end
            end

            c_ST_HALTED: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = c_ST_START;
            end
        endcase

        // halt overrides jump and stall in every state; any outstanding
        // request is simply abandoned.
        if (halt) begin
            state_d  = c_ST_HALTED;
            valid_d  = 1'b0;
            squash_d = 1'b0;
            gap_d    = 1'b0;
            wrap_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_START;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            hold_addr_q <= RESET_PC;
            gap_q       <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            hold_addr_q <= hold_addr_d;
            gap_q       <= gap_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_fetch_unit
// Description : Self-checking bench for dsp_fetch_unit. A memory responder
//               acks requests under bench control. Every instruction the
//               bench intends to be issued is pushed as {pc,data} into a
//               scoreboard queue. A monitor pops the queue on each new
//               instr_valid and compares against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dsp_fetch_unit;

    localparam int c_AW = 10;
    localparam int c_IW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            jump_flag;
    logic [c_AW-1:0] jump_addr;
    logic            stall;
    logic            halt;
    logic            imem_req;
    logic [c_AW-1:0] imem_addr;
    logic            imem_ack;
    logic [c_IW-1:0] imem_data;
    logic [c_IW-1:0] instr;
    logic [c_AW-1:0] instr_pc;
    logic            instr_valid;
    logic            pc_wrap;
    logic            halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [c_AW+c_IW-1:0] sb_q[$];
    logic                 prev_valid = 1'b0;

    dsp_fetch_unit #(
        .ADDR_W   (c_AW),
        .INSTR_W  (c_IW),
        .RESET_PC (10'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .stall       (stall),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .pc_wrap     (pc_wrap),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic ack_cycle(input logic [c_IW-1:0] d);
        imem_ack  = 1'b1;
        imem_data = d;
        tick();
        imem_ack  = 1'b0;
        imem_data = '0;
    endtask

    // Serve one request at address a after lat cycles; the word is expected
    // to reach the decoder.
    task automatic fetch(input logic [c_AW-1:0] a, input logic [c_IW-1:0] d, input int lat);
        wait_req();
        chk("fetch_addr", {22'd0, imem_addr}, {22'd0, a});
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("addr_hold", {22'd0, imem_addr}, {22'd0, a});
        end
        sb_q.push_back({a, d});
        ack_cycle(d);
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_req_low", {31'd0, imem_req}, 32'd0);
    endtask

    // Scoreboard monitor: every fresh instruction must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (instr_valid && !prev_valid) begin
                chk("sb_depth", sb_q.size(), 32'd1);
                if (sb_q.size() > 0) begin
                    logic [c_AW+c_IW-1:0] e;
                    e = sb_q.pop_front();
                    chk("sb_instr_pc", {22'd0, instr_pc}, {22'd0, e[c_AW+c_IW-1:c_IW]});
                    chk("sb_instr", {16'd0, instr}, {16'd0, e[c_IW-1:0]});
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; jump_flag = 1'b0; jump_addr = '0; stall = 1'b0;
        halt = 1'b0; imem_ack = 1'b0; imem_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  {22'd0, imem_addr},   32'd0);
        chk("rst_instr", {16'd0, instr},       32'd0);
        chk("rst_ipc",   {22'd0, instr_pc},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_wrap",  {31'd0, pc_wrap},     32'd0);
        chk("rst_halt",  {31'd0, halted},      32'd0);

        // 1: START one cycle, then first fetch at RESET_PC
        rst = 1'b0;
        chk("start_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        fetch(10'h000, 16'h1234, 1);

        // 2: stall holds the instruction for 3 cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", {16'd0, instr},       32'h1234);
            chk("stall_ipc",   {22'd0, instr_pc},    32'd0);
            chk("stall_req",   {31'd0, imem_req},    32'd0);
        end
        stall = 1'b0;
        tick();
        chk("consume_valid", {31'd0, instr_valid}, 32'd0);
        chk("consume_req",   {31'd0, imem_req},    32'd1);
        chk("consume_addr",  {22'd0, imem_addr},   32'd1);
        chk("consume_wrap",  {31'd0, pc_wrap},     32'd0);
        fetch(10'h001, 16'hA001, 1);

        // 3: jump in ISSUE with stall squashes the held instruction
        stall = 1'b1; jump_flag = 1'b1; jump_addr = 10'h155;
        tick();
        stall = 1'b0; jump_flag = 1'b0;
        chk("jmp_issue_valid", {31'd0, instr_valid}, 32'd0);
        chk("jmp_issue_req",   {31'd0, imem_req},    32'd1);
        chk("jmp_issue_addr",  {22'd0, imem_addr},   32'h155);
        fetch(10'h155, 16'hBEEF, 2);

        // 4: jump to 0x005 without stall, then a jump over the live request
        jump_flag = 1'b1; jump_addr = 10'h005;
        tick();
        chk("jmp_nostall_valid", {31'd0, instr_valid}, 32'd0);
        chk("jmp_nostall_addr",  {22'd0, imem_addr},   32'h005);
        jump_addr = 10'h020;
        tick();
        jump_flag = 1'b0;
        chk("sq_req",   {31'd0, imem_req},  32'd1);
        chk("sq_addr0", {22'd0, imem_addr}, 32'h005);
        tick();
        chk("sq_addr1", {22'd0, imem_addr}, 32'h005);
        ack_cycle(16'hDEAD);
        chk("sq_drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("sq_gap_req",    {31'd0, imem_req},    32'd0);
        tick();
        chk("sq_refetch_req",  {31'd0, imem_req},  32'd1);
        chk("sq_refetch_addr", {22'd0, imem_addr}, 32'h020);
        fetch(10'h020, 16'hC0DE, 1);

        // 5: PC wrap
        jump_flag = 1'b1; jump_addr = 10'h3FF;
        tick();
        jump_flag = 1'b0;
        fetch(10'h3FF, 16'h5A5A, 1);
        tick();
        chk("wrap_pulse", {31'd0, pc_wrap},   32'd1);
        chk("wrap_addr",  {22'd0, imem_addr}, 32'd0);
        chk("wrap_req",   {31'd0, imem_req},  32'd1);
        tick();
        chk("wrap_clear", {31'd0, pc_wrap},   32'd0);

        // 6: halt with simultaneous jump during FETCH
        halt = 1'b1; jump_flag = 1'b1; jump_addr = 10'h100;
        tick();
        halt = 1'b0; jump_flag = 1'b0;
        chk("halt_flag",  {31'd0, halted},      32'd1);
        chk("halt_req",   {31'd0, imem_req},    32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        ack_cycle(16'hFFFF);
        jump_flag = 1'b1; jump_addr = 10'h200;
        tick();
        jump_flag = 1'b0;
        tick();
        chk("halt_sticky", {31'd0, halted},      32'd1);
        chk("halt_noissue",{31'd0, instr_valid}, 32'd0);
        chk("halt_req2",   {31'd0, imem_req},    32'd0);

        rst = 1'b1;
        tick();
        chk("rerst_halt", {31'd0, halted},    32'd0);
        chk("rerst_req",  {31'd0, imem_req},  32'd0);
        chk("rerst_addr", {22'd0, imem_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line run with varying memory latency and stalls
        for (int i = 0; i < 4; i++) begin
            fetch(i[c_AW-1:0], 16'h1000 + i[c_IW-1:0], i + 1);
            if (i == 1) begin
                stall = 1'b1;
                tick(); tick();
                stall = 1'b0;
            end
            tick();
            chk("run_consumed", {31'd0, instr_valid}, 32'd0);
        end
        chk("run_next_addr", {22'd0, imem_addr}, 32'd4);
        chk("sb_empty_end", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
